// File: rtl/rps_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rps_match_ctrl
// Brief    : Match sequencer for the rock-paper-scissors judge. It collects
//            one move per player through a valid/lock handshake, starts the
//            judge, scores each round and ends the match on a win target or
//            a round limit. Move and judge timeouts keep the match moving.
// Revision : 1.0 - initial release
// ============================================================================
module rps_match_ctrl #(
   parameter int WIN_TARGET    = 3,
   parameter int MAX_ROUNDS    = 9,
   parameter int MOVE_TIMEOUT  = 1000,
   parameter int JUDGE_TIMEOUT = 8,
   parameter int SCORE_W       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               new_match,
   input  logic               p1_valid,
   input  logic [1:0]         p1_move,
   input  logic               p2_valid,
   input  logic [1:0]         p2_move,
   output logic               p1_locked,
   output logic               p2_locked,
   output logic [1:0]         judge_move1,
   output logic [1:0]         judge_move2,
   output logic               judge_start,
   input  logic [1:0]         judge_result,
   input  logic               judge_ready,
   output logic               round_done,
   output logic [1:0]         round_result,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic [SCORE_W-1:0] round_cnt,
   output logic               match_busy,
   output logic               match_done,
   output logic [1:0]         match_winner,
   output logic               judge_err
);

   // One shared timer serves both COLLECT and WAIT; it never holds both at once.
   localparam int TMR_MAX = (MOVE_TIMEOUT > JUDGE_TIMEOUT) ? MOVE_TIMEOUT : JUDGE_TIMEOUT;
   localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

   localparam logic [TMR_W-1:0]   c_move_last  = TMR_W'(MOVE_TIMEOUT - 1);
   localparam logic [TMR_W-1:0]   c_judge_last = TMR_W'(JUDGE_TIMEOUT - 1);
   localparam logic [SCORE_W-1:0] c_win        = SCORE_W'(WIN_TARGET);
   localparam logic [SCORE_W-1:0] c_max        = SCORE_W'(MAX_ROUNDS);

   // Result / winner codes
   localparam logic [1:0] c_res_void = 2'b00;
   localparam logic [1:0] c_res_p1   = 2'b01;
   localparam logic [1:0] c_res_p2   = 2'b10;
   localparam logic [1:0] c_res_tie  = 2'b11;
   localparam logic [1:0] c_mv_bad   = 2'b11;

   // Match states
   localparam logic [2:0] c_idle    = 3'd0;
   localparam logic [2:0] c_collect = 3'd1;
   localparam logic [2:0] c_start   = 3'd2;
   localparam logic [2:0] c_wait    = 3'd3;
   localparam logic [2:0] c_score   = 3'd4;
   localparam logic [2:0] c_done    = 3'd5;

   logic [2:0]         state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               p1_locked_q, p1_locked_d;
   logic               p2_locked_q, p2_locked_d;
   logic [1:0]         judge_move1_q, judge_move1_d;
   logic [1:0]         judge_move2_q, judge_move2_d;
   logic               judge_start_q, judge_start_d;
   logic               round_done_q, round_done_d;
   logic [1:0]         round_result_q, round_result_d;
   logic [SCORE_W-1:0] p1_score_q, p1_score_d;
   logic [SCORE_W-1:0] p2_score_q, p2_score_d;
   logic [SCORE_W-1:0] round_cnt_q, round_cnt_d;
   logic               match_busy_q, match_busy_d;
   logic               match_done_q, match_done_d;
   logic [1:0]         match_winner_q, match_winner_d;
   logic               judge_err_q, judge_err_d;

   logic               w_cap1, w_cap2;

   // Next-state, capture, scoring and registered-output decode
   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      p1_locked_d    = p1_locked_q;
      p2_locked_d    = p2_locked_q;
      judge_move1_d  = judge_move1_q;
      judge_move2_d  = judge_move2_q;
      round_result_d = round_result_q;
      p1_score_d     = p1_score_q;
      p2_score_d     = p2_score_q;
      round_cnt_d    = round_cnt_q;
      match_winner_d = match_winner_q;
      judge_err_d    = judge_err_q;

      // First legal strobe per round wins; later strobes and 11 are dropped.
      w_cap1 = (state_q == c_collect) && p1_valid && (p1_move != c_mv_bad) && !p1_locked_q;
      w_cap2 = (state_q == c_collect) && p2_valid && (p2_move != c_mv_bad) && !p2_locked_q;

      case (state_q)
         c_idle, c_done: begin
            if (new_match) begin
               state_d        = c_collect;
               timer_d        = '0;
               p1_locked_d    = 1'b0;
               p2_locked_d    = 1'b0;
               round_result_d = c_res_void;
               p1_score_d     = '0;
               p2_score_d     = '0;
               round_cnt_d    = '0;
               match_winner_d = 2'b00;
               judge_err_d    = 1'b0;
            end
         end
         c_collect: begin
            if (w_cap1) begin
               p1_locked_d   = 1'b1;
               judge_move1_d = p1_move;
            end
            if (w_cap2) begin
               p2_locked_d   = 1'b1;
               judge_move2_d = p2_move;
            end
            // A lock landing on the timeout cycle still completes the pair.
            if (p1_locked_d && p2_locked_d) begin
               state_d = c_start;
            end else if (timer_q == c_move_last) begin
               state_d = c_score;
               if (p1_locked_d)      round_result_d = c_res_p1;
               else if (p2_locked_d) round_result_d = c_res_p2;
               else                  round_result_d = c_res_tie;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         c_start: begin
            // Any judge_ready seen here is the previous round's stale result.
            state_d = c_wait;
            timer_d = '0;
         end
         c_wait: begin
            if (judge_ready && (judge_result != c_res_void)) begin
               state_d        = c_score;
               round_result_d = judge_result;
            end else if (timer_q == c_judge_last) begin
               state_d        = c_score;
               round_result_d = c_res_void;
               judge_err_d    = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         c_score: begin
            p1_locked_d = 1'b0;
            p2_locked_d = 1'b0;
            if (p1_score_q == c_win) begin
               state_d        = c_done;
               match_winner_d = c_res_p1;
            end else if (p2_score_q == c_win) begin
               state_d        = c_done;
               match_winner_d = c_res_p2;
            end else if (round_cnt_q == c_max) begin
               state_d = c_done;
               if (p1_score_q > p2_score_q)      match_winner_d = c_res_p1;
               else if (p2_score_q > p1_score_q) match_winner_d = c_res_p2;
               else                              match_winner_d = c_res_tie;
            end else begin
               state_d = c_collect;
               timer_d = '0;
            end
         end
         default: begin
            state_d = c_idle;
         end
      endcase

      // Counters move on the SCORE-entry edge so they line up with round_done.
      if ((state_q != c_score) && (state_d == c_score)) begin
         round_cnt_d = round_cnt_q + 1'b1;
         if (round_result_d == c_res_p1) p1_score_d = p1_score_q + 1'b1;
         if (round_result_d == c_res_p2) p2_score_d = p2_score_q + 1'b1;
      end

      judge_start_d = (state_d == c_start);
      round_done_d  = (state_d == c_score);
      match_busy_d  = (state_d == c_collect) || (state_d == c_start) ||
                      (state_d == c_wait)    || (state_d == c_score);
      match_done_d  = (state_d == c_done);
   end

   // State and output registers; reset aborts any match straight to IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= c_idle;
         timer_q        <= '0;
         p1_locked_q    <= 1'b0;
         p2_locked_q    <= 1'b0;
         judge_move1_q  <= 2'b00;
         judge_move2_q  <= 2'b00;
         judge_start_q  <= 1'b0;
         round_done_q   <= 1'b0;
         round_result_q <= 2'b00;
         p1_score_q     <= '0;
         p2_score_q     <= '0;
         round_cnt_q    <= '0;
         match_busy_q   <= 1'b0;
         match_done_q   <= 1'b0;
         match_winner_q <= 2'b00;
         judge_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         p1_locked_q    <= p1_locked_d;
         p2_locked_q    <= p2_locked_d;
         judge_move1_q  <= judge_move1_d;
         judge_move2_q  <= judge_move2_d;
         judge_start_q  <= judge_start_d;
         round_done_q   <= round_done_d;
         round_result_q <= round_result_d;
         p1_score_q     <= p1_score_d;
         p2_score_q     <= p2_score_d;
         round_cnt_q    <= round_cnt_d;
         match_busy_q   <= match_busy_d;
         match_done_q   <= match_done_d;
         match_winner_q <= match_winner_d;
         judge_err_q    <= judge_err_d;
      end
   end

   assign p1_locked    = p1_locked_q;
   assign p2_locked    = p2_locked_q;
   assign judge_move1  = judge_move1_q;
   assign judge_move2  = judge_move2_q;
   assign judge_start  = judge_start_q;
   assign round_done   = round_done_q;
   assign round_result = round_result_q;
   assign p1_score     = p1_score_q;
   assign p2_score     = p2_score_q;
   assign round_cnt    = round_cnt_q;
   assign match_busy   = match_busy_q;
   assign match_done   = match_done_q;
   assign match_winner = match_winner_q;
   assign judge_err    = judge_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rps_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rps_match_ctrl
// Brief    : Self-checking bench for rps_match_ctrl. Rounds are described as
//            plans (lock cycle per player, moves, judge reply cycle); expected
//            scores and winners come from a round-level match model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rps_match_ctrl;

   localparam int WIN_TARGET    = 3;
   localparam int MAX_ROUNDS    = 9;
   localparam int MOVE_TIMEOUT  = 12;
   localparam int JUDGE_TIMEOUT = 6;
   localparam int SCORE_W       = 4;
   localparam int NEVER         = 1000;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               new_match = 1'b0;
   logic               p1_valid = 1'b0;
   logic [1:0]         p1_move = 2'b00;
   logic               p2_valid = 1'b0;
   logic [1:0]         p2_move = 2'b00;
   logic               p1_locked, p2_locked;
   logic [1:0]         judge_move1, judge_move2;
   logic               judge_start;
   logic [1:0]         judge_result = 2'b00;
   logic               judge_ready = 1'b0;
   logic               round_done;
   logic [1:0]         round_result;
   logic [SCORE_W-1:0] p1_score, p2_score, round_cnt;
   logic               match_busy, match_done;
   logic [1:0]         match_winner;
   logic               judge_err;

   int n_chk = 0;
   int n_bad = 0;

   // round-level match model
   int s1, s2, cnt, jerr;
   bit over;

   rps_match_ctrl #(
      .WIN_TARGET   (WIN_TARGET),
      .MAX_ROUNDS   (MAX_ROUNDS),
      .MOVE_TIMEOUT (MOVE_TIMEOUT),
      .JUDGE_TIMEOUT(JUDGE_TIMEOUT),
      .SCORE_W      (SCORE_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .new_match   (new_match),
      .p1_valid    (p1_valid),
      .p1_move     (p1_move),
      .p2_valid    (p2_valid),
      .p2_move     (p2_move),
      .p1_locked   (p1_locked),
      .p2_locked   (p2_locked),
      .judge_move1 (judge_move1),
      .judge_move2 (judge_move2),
      .judge_start (judge_start),
      .judge_result(judge_result),
      .judge_ready (judge_ready),
      .round_done  (round_done),
      .round_result(round_result),
      .p1_score    (p1_score),
      .p2_score    (p2_score),
      .round_cnt   (round_cnt),
      .match_busy  (match_busy),
      .match_done  (match_done),
      .match_winner(match_winner),
      .judge_err   (judge_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Rock-paper-scissors outcome from move arithmetic: a beats b when a-b = 1 mod 3.
   function automatic logic [1:0] rps(input logic [1:0] a, input logic [1:0] b);
      int d;
      d = (int'(a) - int'(b) + 3) % 3;
      if (d == 0)      return 2'b11;
      else if (d == 1) return 2'b01;
      else             return 2'b10;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_locks"},  {30'd0, p1_locked, p2_locked}, 0);
      check({tag, "_moves"},  {28'd0, judge_move1, judge_move2}, 0);
      check({tag, "_pulses"}, {30'd0, judge_start, round_done}, 0);
      check({tag, "_result"}, round_result, 0);
      check({tag, "_scores"}, {p1_score, p2_score, round_cnt}, 0);
      check({tag, "_flags"},  {29'd0, match_busy, match_done, judge_err}, 0);
      check({tag, "_winner"}, match_winner, 0);
   endtask

   task automatic junk_strobes();
      p1_valid = 1'($urandom % 2);
      p1_move  = 2'($urandom % 4);
      p2_valid = 1'($urandom % 2);
      p2_move  = 2'($urandom % 4);
   endtask

   // Issue new_match from IDLE/DONE; next cycle is COLLECT with a clean slate.
   task automatic start_match();
      new_match = 1'b1;
      junk_strobes();
      p1_valid = 1'b0;
      p2_valid = 1'b0;
      step();
      new_match = 1'b0;
      s1 = 0; s2 = 0; cnt = 0; jerr = 0; over = 1'b0;
      check("start_busy", match_busy, 1);
      check("start_done", match_done, 0);
      check("start_scores", {p1_score, p2_score, round_cnt}, 0);
      check("start_err", judge_err, 0);
      check("start_winner", match_winner, 0);
      check("start_result", round_result, 0);
   endtask

   // One round from COLLECT cycle 0 through the cycle after SCORE.
   // dN: COLLECT cycle of the legal strobe (>= MOVE_TIMEOUT means never),
   // jd: WAIT cycle of the judge reply (>= JUDGE_TIMEOUT means never).
   task automatic play_round(input int d1, input int d2, input logic [1:0] m1,
                             input logic [1:0] m2, input int jd, input bit illegal_pre);
      bit l1, l2;
      logic [1:0] res;
      int w;
      l1 = 1'b0;
      l2 = 1'b0;
      judge_ready = 1'b0;
      for (int k = 0; k < MOVE_TIMEOUT; k++) begin
         if (k == d1) begin
            p1_valid = 1'b1; p1_move = m1;
         end else if (k < d1) begin
            p1_valid = illegal_pre ? 1'b1 : 1'($urandom % 2); p1_move = 2'b11;
         end else begin
            p1_valid = 1'($urandom % 2); p1_move = 2'($urandom % 4);
         end
         if (k == d2) begin
            p2_valid = 1'b1; p2_move = m2;
         end else if (k < d2) begin
            p2_valid = illegal_pre ? 1'b1 : 1'($urandom % 2); p2_move = 2'b11;
         end else begin
            p2_valid = 1'($urandom % 2); p2_move = 2'($urandom % 4);
         end
         new_match = 1'(($urandom % 4) == 0);
         step();
         if (k == d1) l1 = 1'b1;
         if (k == d2) l2 = 1'b1;
         check("p1_lock", p1_locked, l1);
         check("p2_lock", p2_locked, l2);
         if (l1 && l2) break;
      end

      if (l1 && l2) begin
         check("start_pulse", judge_start, 1);
         check("judge_move1", judge_move1, m1);
         check("judge_move2", judge_move2, m2);
         // stale judge output while in START must be ignored
         judge_ready  = 1'b1;
         judge_result = 2'($urandom_range(1, 3));
         junk_strobes();
         new_match = 1'(($urandom % 4) == 0);
         step();
         check("start_one_cycle", judge_start, 0);
         res = rps(m1, m2);
         for (int j = 0; j < JUDGE_TIMEOUT; j++) begin
            if (j == jd) begin
               judge_ready = 1'b1; judge_result = res;
            end else begin
               judge_ready = 1'(($urandom % 3) == 0); judge_result = 2'b00;
            end
            junk_strobes();
            new_match = 1'(($urandom % 4) == 0);
            step();
            if (j == jd) break;
         end
         if (jd >= JUDGE_TIMEOUT) begin
            res  = 2'b00;
            jerr = 1;
         end
      end else begin
         res = l1 ? 2'b01 : (l2 ? 2'b10 : 2'b11);
      end

      judge_ready  = 1'b0;
      judge_result = 2'b00;
      cnt++;
      if (res == 2'b01) s1++;
      if (res == 2'b10) s2++;

      // SCORE cycle
      check("round_done", round_done, 1);
      check("round_result", round_result, res);
      check("p1_score", p1_score, s1);
      check("p2_score", p2_score, s2);
      check("round_cnt", round_cnt, cnt);
      check("judge_err", judge_err, jerr);
      check("score_busy", match_busy, 1);

      w = 0;
      if (s1 == WIN_TARGET)      w = 1;
      else if (s2 == WIN_TARGET) w = 2;
      else if (cnt == MAX_ROUNDS) w = (s1 > s2) ? 1 : ((s2 > s1) ? 2 : 3);
      over = (w != 0);

      junk_strobes();
      new_match = 1'(($urandom % 4) == 0);
      step();
      new_match = 1'b0;
      check("round_done_clear", round_done, 0);
      check("locks_clear", {p1_locked, p2_locked}, 0);
      check("match_done", match_done, over);
      if (over) begin
         check("match_winner", match_winner, w);
         check("done_busy", match_busy, 0);
      end
   endtask

   initial begin
      // reset
      repeat (3) step();
      check_all_zero("reset");
      rst = 1'b0;
      step();
      check_all_zero("idle");

      // P1 rock beats P2 scissors three times, nominal judge
      start_match();
      for (int r = 0; r < 3; r++) play_round(0, 0, 2'b00, 2'b10, 1, 1'b0);
      check("m1_over", over, 1);
      repeat (2) step();
      check("m1_hold_done", match_done, 1);
      check("m1_hold_cnt", round_cnt, 3);
      check("m1_hold_winner", match_winner, 2'b01);

      // same-cycle locks with later junk; illegal strobes before a late lock
      start_match();
      play_round(0, 0, 2'b01, 2'b01, 1, 1'b0);
      play_round(3, 1, 2'b00, 2'b01, 0, 1'b1);
      // forfeits: only p2, then neither; judge timeout voids; then p2 wins out
      play_round(NEVER, 2, 2'b00, 2'b10, 1, 1'b0);
      play_round(NEVER, NEVER, 2'b00, 2'b00, 1, 1'b0);
      play_round(0, MOVE_TIMEOUT - 1, 2'b10, 2'b00, NEVER, 1'b0);
      play_round(MOVE_TIMEOUT - 1, NEVER, 2'b00, 2'b00, 1, 1'b0);
      for (int r = 0; r < MAX_ROUNDS && !over; r++) play_round(NEVER, 0, 2'b00, 2'b01, 1, 1'b0);
      check("m2_over", over, 1);
      start_match();

      // nine judged ties -> draw on the round limit
      for (int r = 0; r < MAX_ROUNDS; r++)
         play_round(r % 2, 1, 2'(r % 3), 2'(r % 3), 1 + (r % 3), 1'b0);
      check("tie_over", over, 1);

      // randomized matches
      for (int m = 0; m < 6; m++) begin
         start_match();
         for (int r = 0; r < MAX_ROUNDS && !over; r++) begin
            int d1, d2, jd;
            d1 = (($urandom % 5) == 0) ? int'($urandom_range(0, MOVE_TIMEOUT + 2)) : int'($urandom_range(0, 5));
            d2 = (($urandom % 5) == 0) ? int'($urandom_range(0, MOVE_TIMEOUT + 2)) : int'($urandom_range(0, 5));
            jd = (($urandom % 4) == 0) ? int'($urandom_range(0, JUDGE_TIMEOUT + 1)) : 1;
            play_round(d1, d2, 2'($urandom % 3), 2'($urandom % 3), jd, 1'($urandom % 2));
         end
         check("rand_over", over, 1);
      end

      // reset while waiting on the judge aborts cleanly
      start_match();
      play_round(0, 0, 2'b01, 2'b00, 1, 1'b0);
      p1_valid = 1'b1; p1_move = 2'b10;
      p2_valid = 1'b1; p2_move = 2'b01;
      step();
      check("abort_start", judge_start, 1);
      p1_valid = 1'b0; p2_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      check_all_zero("abort");
      rst = 1'b0;
      step();
      check_all_zero("abort_idle");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rps_match_ctrl.md
Name: rps_match_ctrl

Overview:
Match sequencer for the rock-paper-scissors judge block. It collects one move per player per round through a valid/lock handshake, presents the locked moves to the judge and pulses its start, then waits for judge ready. It scores the result and ends the match on a first-to-WIN_TARGET or MAX_ROUNDS limit. Player move-timeout forfeits and judge-timeout void rounds are handled here, so the judge never stalls the match.

Parameters:
WIN_TARGET, 3, round wins that end the match immediately
MAX_ROUNDS, 9, max judged or forfeited rounds per match; require WIN_TARGET <= MAX_ROUNDS < 2^SCORE_W
MOVE_TIMEOUT, 1000, cycles allowed in COLLECT before forfeit; >= 2
JUDGE_TIMEOUT, 8, cycles allowed in WAIT for judge_ready; >= 2
SCORE_W, 4, width of score and round counters

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
new_match  in  1  pulse; starts a match, honoured only in IDLE or DONE
p1_valid  in  1  player 1 move strobe
p1_move  in  2  00 ROCK, 01 PAPER, 10 SCISSORS; 11 illegal
p2_valid  in  1  player 2 move strobe
p2_move  in  2  same encoding as p1_move
p1_locked  out  1  player 1 move captured this round
p2_locked  out  1  player 2 move captured this round
judge_move1  out  2  locked p1 move to judge
judge_move2  out  2  locked p2 move to judge
judge_start  out  1  one-cycle start pulse to judge
judge_result  in  2  00 NONE, 01 P1WIN, 10 P2WIN, 11 TIE
judge_ready  in  1  judge result valid (result != NONE)
round_done  out  1  one-cycle pulse per completed round
round_result  out  2  result of last round, same encoding as judge_result; 00 = void
p1_score  out  SCORE_W  rounds won by player 1
p2_score  out  SCORE_W  rounds won by player 2
round_cnt  out  SCORE_W  rounds completed, including ties, forfeits and voids
match_busy  out  1  high from COLLECT through SCORE
match_done  out  1  high in DONE
match_winner  out  2  01 p1, 10 p2, 11 draw; valid while match_done
judge_err  out  1  sticky; set on any judge timeout, cleared by new_match

Behaviour:
- Reset: state IDLE; all outputs 0, including locks, judge_move1/2, scores, round_cnt, round_result and judge_err. Reset mid-match aborts to IDLE with no round_done pulse.
- States: IDLE, COLLECT, START, WAIT, SCORE, DONE. All outputs are registered.
- IDLE/DONE + new_match: clear scores, round_cnt, round_result, judge_err, locks and match_winner; enter COLLECT. new_match is ignored in all other states.
- COLLECT:
  - Move timer clears on entry and increments every cycle.
  - A pN_valid with a legal move and pN_locked=0 captures the move into judge_moveN and sets pN_locked.
  - Illegal move 11 is ignored. Strobes after the lock are ignored; the first capture wins.
  - Both players locked, including the same cycle, means next state START.
  - If the timer reaches MOVE_TIMEOUT-1 without both locked, go to SCORE with a forfeit result: only p1 locked gives 01, only p2 locked gives 10, neither locked gives 11 (tie).
  - A lock arriving on the timeout cycle counts. If that completes both locks, the round goes to START.
- START: judge_start=1 for exactly this cycle; judge_move1/2 stay held. judge_ready is ignored here, because the judge's stale result drops only on start. Next state WAIT.
- WAIT:
  - Judge timer clears on entry.
  - The first cycle with judge_ready=1 and judge_result != 00 latches round_result and goes to SCORE. Nominally this is the 2nd WAIT cycle.
  - At JUDGE_TIMEOUT cycles with no ready: round_result=00 (void), judge_err set, go to SCORE.
- SCORE (one cycle): round_done=1.
  - round_cnt increments.
  - 01 increments p1_score, 10 increments p2_score; 11 and 00 change neither score.
  - Counters update on the SCORE-entry edge, so they are valid together with round_done.
  - Locks clear on leaving SCORE.
  - If either score equals WIN_TARGET, go to DONE with that player as winner.
  - Else if round_cnt equals MAX_ROUNDS, go to DONE: the higher score wins, equal scores give 11.
  - Otherwise go to COLLECT.
- DONE: match_done=1; scores, round_cnt and match_winner hold until new_match or rst.
- Latency: both locks captured on edge t, judge_start high in cycle t+1, round_done in cycle t+4 with a nominal judge.
- Counters never wrap, guaranteed by the parameter constraints; saturation is not required.

Test Plan:
- Reset, then new_match. Rounds P1 ROCK/P2 SCISSORS three times -> judge_start pulses 3x; p1_score 1,2,3; DONE with match_winner=01; round_cnt=3.
- Same-cycle strobes, then p1_valid again with a new move while locked -> second strobe ignored; judge_move1 keeps the first move; judge_start exactly one cycle.
- p1_move=11 with p1_valid -> p1_locked stays 0. Then legal ROCK -> captured.
- Only p2 submits and MOVE_TIMEOUT elapses -> no judge_start; round_result=10; p2_score+1. Neither submits -> result 11; scores unchanged; round_cnt+1.
- Judge model holds ready low -> after JUDGE_TIMEOUT WAIT cycles round_result=00 and judge_err=1; scores unchanged. new_match clears judge_err.
- Alternate ties for 9 rounds -> DONE at round_cnt=9 with match_winner=11. rst asserted mid-WAIT in a later match -> next cycle IDLE with all outputs 0.
